// File: rtl/word_burst_byte_writer.sv
// word_burst_byte_writer
//
// Takes a burst command (base byte address, word count, byte order), pulls
// that many words from a valid/ready stream and writes each one, byte by
// byte, into a byte-wide staging RAM. Every byte costs two cycles: a SETUP
// cycle that presents data/address with we=1, followed by a STROBE cycle
// that raises wr_clock. The RAM address ascends across the whole burst and
// wraps from NUMBER-1 back to 0.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   start                command strobe, honoured only while ready=1
//   addr                 burst base byte address
//   len                  words in burst (0 = empty, saturates at MAX_WORDS)
//   msb_first            1: most significant byte first, 0: bits 7:0 first
//   abort                ends an active burst early
//   word/word_valid      input word stream
//   word_ready           stream ready, high only while waiting for a word
//   ready                idle, a start will be accepted
//   done/aborted         one-cycle completion pulse, aborted qualifies it
//   wr_data/wr_addr      RAM write data and address
//   wr_clock/we          RAM write strobe and write enable
//
// All outputs are registered and describe the state occupied in that cycle.

module word_burst_byte_writer #(
    parameter int NUMBER     = 256,
    parameter int WORD_BYTES = 4,
    parameter int MAX_WORDS  = 64,
    localparam int AW = (NUMBER > 1) ? $clog2(NUMBER) : 1,
    localparam int LW = $clog2(MAX_WORDS + 1),
    localparam int WW = 8 * WORD_BYTES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] addr,
    input  logic [LW-1:0] len,
    input  logic          msb_first,
    input  logic          abort,
    input  logic [WW-1:0] word,
    input  logic          word_valid,
    output logic          word_ready,
    output logic          ready,
    output logic          done,
    output logic          aborted,
    output logic [7:0]    wr_data,
    output logic [AW-1:0] wr_addr,
    output logic          wr_clock,
    output logic          we
);

    localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        STROBE,
        FIN
    } state_t;

    state_t        state;
    logic [AW-1:0] addr_cnt;
    logic [LW-1:0] words_left;
    logic [BW-1:0] byte_idx;
    logic          msb_r;
    logic [WW-1:0] shift_buf;

    logic [AW-1:0] addr_next;
    logic [WW-1:0] buf_shifted;
    logic [LW-1:0] len_sat;
    logic          last_byte;

    // The byte going out next always sits at one end of the shift buffer;
    // which end depends on the latched byte order.
    function automatic logic [7:0] pick_byte(input logic [WW-1:0] v, input logic msb);
        return msb ? v[WW-1 -: 8] : v[7:0];
    endfunction

    // Explicit compare against NUMBER-1 so non-power-of-2 depths wrap correctly.
    always_comb begin
        addr_next   = (addr_cnt == AW'(NUMBER - 1)) ? '0 : addr_cnt + AW'(1);
        buf_shifted = msb_r ? (shift_buf << 8) : (shift_buf >> 8);
        len_sat     = (len > LW'(MAX_WORDS)) ? LW'(MAX_WORDS) : len;
        last_byte   = (byte_idx == BW'(WORD_BYTES - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ready      <= 1'b1;
            word_ready <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            wr_data    <= '0;
            wr_addr    <= '0;
            wr_clock   <= 1'b0;
            we         <= 1'b0;
            addr_cnt   <= '0;
            words_left <= '0;
            byte_idx   <= '0;
            msb_r      <= 1'b0;
            shift_buf  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_cnt   <= addr;
                        words_left <= len_sat;
                        msb_r      <= msb_first;
                        ready      <= 1'b0;
                        if (len_sat == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state      <= LOAD;
                            word_ready <= 1'b1;
                        end
                    end
                end

                // Abort has priority over a simultaneous transfer, so the
                // offered word is left in the stream.
                LOAD: begin
                    if (abort) begin
                        state      <= FIN;
                        word_ready <= 1'b0;
                        done       <= 1'b1;
                        aborted    <= 1'b1;
                    end else if (word_valid) begin
                        shift_buf  <= word;
                        byte_idx   <= '0;
                        word_ready <= 1'b0;
                        we         <= 1'b1;
                        wr_data    <= pick_byte(word, msb_r);
                        wr_addr    <= addr_cnt;
                        state      <= SETUP;
                    end
                end

                SETUP: begin
                    if (abort) begin
                        state   <= FIN;
                        we      <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else begin
                        state    <= STROBE;
                        wr_clock <= 1'b1;
                    end
                end

                // The strobe in progress always completes; abort only stops
                // what would have followed it.
                STROBE: begin
                    addr_cnt <= addr_next;
                    wr_clock <= 1'b0;
                    if (abort) begin
                        state   <= FIN;
                        we      <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (!last_byte) begin
                        byte_idx  <= byte_idx + BW'(1);
                        shift_buf <= buf_shifted;
                        wr_data   <= pick_byte(buf_shifted, msb_r);
                        wr_addr   <= addr_next;
                        state     <= SETUP;
                    end else begin
                        words_left <= words_left - LW'(1);
                        we         <= 1'b0;
                        if (words_left == LW'(1)) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state      <= LOAD;
                            word_ready <= 1'b1;
                        end
                    end
                end

                FIN: begin
                    done    <= 1'b0;
                    aborted <= 1'b0;
                    ready   <= 1'b1;
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_word_burst_byte_writer.sv
// tb_word_burst_byte_writer
//
// Drives bursts into word_burst_byte_writer and compares the RAM write
// sequence, handshake counts, completion pulse and timing against a model
// that derives the expected (address, byte) list directly from the burst
// parameters and the words offered.

module tb_word_burst_byte_writer;

    localparam int NUMBER     = 256;
    localparam int WORD_BYTES = 4;
    localparam int MAX_WORDS  = 64;
    localparam int AW = (NUMBER > 1) ? $clog2(NUMBER) : 1;
    localparam int LW = $clog2(MAX_WORDS + 1);
    localparam int WW = 8 * WORD_BYTES;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic          msb_first;
    logic          abort;
    logic [WW-1:0] word;
    logic          word_valid;
    logic          word_ready;
    logic          ready;
    logic          done;
    logic          aborted;
    logic [7:0]    wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_clock;
    logic          we;

    int total = 0;
    int bad   = 0;
    logic [WW-1:0] stim_words[$];

    word_burst_byte_writer #(
        .NUMBER    (NUMBER),
        .WORD_BYTES(WORD_BYTES),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .addr      (addr),
        .len       (len),
        .msb_first (msb_first),
        .abort     (abort),
        .word      (word),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .ready     (ready),
        .done      (done),
        .aborted   (aborted),
        .wr_data   (wr_data),
        .wr_addr   (wr_addr),
        .wr_clock  (wr_clock),
        .we        (we)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // All outputs packed together for reset-value checks.
    function automatic logic [63:0] outVec();
        return 64'({ready, word_ready, done, aborted, wr_clock, we, wr_addr, wr_data});
    endfunction

    localparam logic [63:0] RESET_VEC = 64'({1'b1, 5'b0, {AW{1'b0}}, 8'h00});

    // Runs one burst. abort_mode: 0 none, 1 abort during strobe number
    // abort_n (1-based), 2 abort in LOAD while word abort_n is offered.
    task automatic applyStimulus(input logic [AW-1:0] b_addr, input int b_len, input bit b_msb,
                                 input int stall, input int abort_mode, input int abort_n,
                                 input bit spurious, input string name);
        int sat;
        int nb;
        int exp_xfers;
        int k;
        int wi;
        int stall_cnt;
        int strobes;
        int xfers;
        int done_cnt;
        int done_k;
        int first_k;
        int abort_k;
        int viol;
        bit ab_seen;
        bit finished;
        logic prev_we;
        logic prev_clk;
        logic [AW-1:0] prev_addr;
        logic [7:0] prev_data;
        logic [WW-1:0] words[$];
        logic [AW+7:0] got[$];
        logic [WW-1:0] w;
        logic [7:0] eb;
        logic [AW-1:0] ea;

        sat = (b_len > MAX_WORDS) ? MAX_WORDS : b_len;
        words = stim_words;
        while (words.size() < sat) words.push_back(WW'({$urandom(), $urandom()}));
        nb = sat * WORD_BYTES;
        exp_xfers = sat;
        if (abort_mode == 1) begin
            nb = abort_n;
            exp_xfers = (abort_n + WORD_BYTES - 1) / WORD_BYTES;
        end else if (abort_mode == 2) begin
            nb = (abort_n - 1) * WORD_BYTES;
            exp_xfers = abort_n - 1;
        end

        wi = 0; stall_cnt = 0; strobes = 0; xfers = 0; done_cnt = 0;
        done_k = -1; first_k = -1; abort_k = -1; viol = 0; ab_seen = 0; finished = 0;

        @(negedge clk);
        start      = 1'b1;
        addr       = b_addr;
        len        = LW'(b_len);
        msb_first  = b_msb;
        abort      = 1'b0;
        word_valid = (sat > 0);
        word       = (sat > 0) ? words[0] : '0;
        prev_we = we; prev_clk = wr_clock; prev_addr = wr_addr; prev_data = wr_data;

        k = 0;
        while (k < 3000 && !finished) begin
            @(negedge clk);
            k++;
            if (wr_clock) begin
                strobes++;
                if (first_k < 0) first_k = k;
                if (!(prev_we && !prev_clk && prev_addr == wr_addr && prev_data == wr_data)) viol++;
                got.push_back({wr_addr, wr_data});
            end
            if (we && word_ready) viol++;
            if (wr_clock && !we) viol++;
            if (done && we) viol++;
            if (done) begin
                done_cnt++;
                done_k = k;
                ab_seen = aborted;
            end
            prev_we = we; prev_clk = wr_clock; prev_addr = wr_addr; prev_data = wr_data;

            if (done_k > 0 && k == done_k + 1) begin
                checkOutput({name, "_ready_after"}, ready, 1'b1);
                checkOutput({name, "_done_width"}, done, 1'b0);
                finished = 1;
            end

            start = spurious && (k == 4);
            if (start) begin
                addr = AW'(8'h55);
                len  = LW'(1);
            end
            abort = 1'b0;
            if (abort_mode == 1 && wr_clock && strobes == abort_n) abort = 1'b1;
            if (abort_mode == 2 && word_ready && wi == abort_n - 1) abort = 1'b1;
            if (abort) abort_k = k;

            if (word_ready && stall_cnt > 0) begin
                word_valid = 1'b0;
                stall_cnt--;
            end else begin
                word_valid = (wi < sat);
                word = (wi < sat) ? words[wi] : '0;
            end
            if (word_ready && word_valid && !abort) begin
                xfers++;
                wi++;
                stall_cnt = stall;
            end
        end

        start = 1'b0; abort = 1'b0; word_valid = 1'b0;
        if (!finished) checkOutput({name, "_timeout"}, 1'b1, 1'b0);

        checkOutput({name, "_done_count"}, done_cnt, 1);
        checkOutput({name, "_aborted"}, ab_seen, abort_mode != 0);
        checkOutput({name, "_strobes"}, strobes, nb);
        checkOutput({name, "_transfers"}, xfers, exp_xfers);
        checkOutput({name, "_protocol"}, viol, 0);
        if (nb > 0) checkOutput({name, "_first_strobe"}, first_k, 3);
        if (abort_mode == 0)
            checkOutput({name, "_done_time"}, done_k,
                        sat * (1 + 2 * WORD_BYTES) + stall * ((sat > 0) ? sat - 1 : 0) + 1);
        else
            checkOutput({name, "_done_time"}, done_k, abort_k + 1);

        for (int i = 0; i < got.size() && i < nb; i++) begin
            w  = words[i / WORD_BYTES];
            if (b_msb) eb = 8'(w >> (8 * (WORD_BYTES - 1 - (i % WORD_BYTES))));
            else       eb = 8'(w >> (8 * (i % WORD_BYTES)));
            ea = AW'((int'(b_addr) + i) % NUMBER);
            checkOutput($sformatf("%s_write%0d", name, i), got[i], {ea, eb});
        end
        stim_words.delete();
    endtask

    initial begin
        int rl;
        int rm;
        int rn;
        int rs;
        int n;
        int sat;
        int resets_done;

        reset = 1'b1;
        start = 1'b0; addr = '0; len = '0; msb_first = 1'b0; abort = 1'b0;
        word = '0; word_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_values", outVec(), RESET_VEC);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_after_reset", outVec(), RESET_VEC);

        stim_words = '{32'hA1B2C3D4};
        applyStimulus(AW'(8'h10), 1, 1'b0, 0, 0, 0, 1'b0, "single");
        stim_words = '{32'h11223344, 32'h55667788};
        applyStimulus(AW'(8'h20), 2, 1'b1, 0, 0, 0, 1'b0, "bigend");
        stim_words = '{32'h0A0B0C0D};
        applyStimulus(AW'(8'hFE), 1, 1'b0, 0, 0, 0, 1'b0, "wrap");
        applyStimulus(AW'(8'h40), 3, 1'b0, 5, 0, 0, 1'b0, "stall");
        applyStimulus(AW'(8'h50), 0, 1'b1, 0, 0, 0, 1'b0, "len0");
        applyStimulus(AW'(8'h60), 3, 1'b0, 0, 1, 2, 1'b1, "abort_strobe");
        applyStimulus(AW'(8'h70), 3, 1'b1, 0, 2, 2, 1'b0, "abort_load");
        applyStimulus(AW'(8'hF0), 100, 1'b0, 0, 0, 0, 1'b0, "saturate");

        // Reset while a write is being set up.
        @(negedge clk);
        start = 1'b1; addr = AW'(8'h30); len = LW'(2); msb_first = 1'b0;
        word = 32'hDEADBEEF; word_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(we && !wr_clock) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reset_reach_setup", we && !wr_clock, 1'b1);
        word_valid = 1'b0;
        #2 reset = 1'b1;
        #1 checkOutput("reset_midburst", outVec(), RESET_VEC);
        @(negedge clk);
        reset = 1'b0;
        resets_done = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) resets_done++;
        end
        checkOutput("reset_no_done", resets_done, 0);
        applyStimulus(AW'(8'h30), 2, 1'b0, 0, 0, 0, 1'b0, "after_reset");

        for (int t = 0; t < 20; t++) begin
            rl = ($urandom_range(0, 9) == 0) ? $urandom_range(MAX_WORDS, 127) : $urandom_range(0, 6);
            sat = (rl > MAX_WORDS) ? MAX_WORDS : rl;
            rs = $urandom_range(0, 3);
            rm = $urandom_range(0, 4);
            rn = 0;
            if (rm == 1 && sat > 0) rn = $urandom_range(1, sat * WORD_BYTES);
            else if (rm == 2 && sat > 0) begin
                rn = $urandom_range(1, sat);
                rs = 0;
            end else rm = 0;
            applyStimulus(AW'($urandom), rl, 1'($urandom), rs, rm, rn, 1'($urandom),
                          $sformatf("rand%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/word_burst_byte_writer.md
Name: word_burst_byte_writer

Overview:
Burst successor to the single-word byte writer. Accepts a start command with base address, word count and byte order. It then pulls words over a valid/ready stream and serialises each word into WORD_BYTES byte writes on a byte-wide RAM port (wr_data/wr_addr/wr_clock/we). It sits between the upgrade control logic and the byte-wide staging RAM in front of the flash/CFM writer.

Parameters:
NUMBER, 256, depth of the target byte RAM; AW = clogb2(NUMBER) (from inc_define.vh)
WORD_BYTES, 4, bytes per input word; word width WW = 8*WORD_BYTES; legal 1..8
MAX_WORDS, 64, maximum words per burst; LW = clogb2(MAX_WORDS+1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  command strobe; accepted only when ready=1
addr  in  AW  burst base byte address
len  in  LW  words in burst; 0 = empty burst; values >MAX_WORDS saturate to MAX_WORDS
msb_first  in  1  1: most significant byte written first; 0: byte 0 (bits 7:0) first
abort  in  1  synchronous abort of an active burst
word  in  WW  stream data
word_valid  in  1  stream valid
word_ready  out  1  stream ready (high only in LOAD)
ready  out  1  idle, can accept start
done  out  1  one-cycle completion pulse
aborted  out  1  qualifies done: burst ended by abort
wr_data  out  8  RAM write data
wr_addr  out  AW  RAM write address
wr_clock  out  1  RAM write strobe
we  out  1  RAM write enable

Behaviour:
- All outputs are registered.
- Reset values: ready=1; word_ready=0, done=0, aborted=0, wr_data=0, wr_addr=0, wr_clock=0, we=0; FSM in IDLE.
- States are IDLE, LOAD, SETUP, STROBE, FIN. Each output reflects the state occupied in that cycle.
- IDLE: ready=1, we=0, wr_clock=0.
  - On start, latch addr into address counter, latch min(len,MAX_WORDS) into words_left, latch msb_first.
  - Go to LOAD, or to FIN if len=0 (no RAM activity).
  - start while not in IDLE is ignored.
- LOAD: word_ready=1, we=0.
  - Transfer occurs when word_valid and word_ready are both 1 on a clock edge; the word is latched into a shift buffer, byte_idx=0, then go to SETUP.
  - Stays in LOAD indefinitely while word_valid=0.
- SETUP: we=1, wr_clock=0. wr_data = current byte, wr_addr = address counter, then go to STROBE.
- STROBE: we=1, wr_clock=1; wr_data/wr_addr held from SETUP.
  - On exit, address counter increments and wraps NUMBER-1 -> 0. For non-power-of-2 NUMBER, compare with NUMBER-1 explicitly.
  - If not the last byte: byte_idx++ and go to SETUP.
  - If last byte: words_left--; go to FIN if 0, else LOAD.
- FIN: done=1 for exactly one cycle, we=0, then go to IDLE (ready=1 the following cycle).
- Byte order:
  - msb_first=0: bytes go out as word[7:0], word[15:8], ...
  - msb_first=1: bytes go out as word[WW-1:WW-8] first, descending.
  - The address always ascends.
- Timing:
  - If start is sampled at edge t0 and word_valid is already high, LOAD occupies t0..t1, SETUP t1..t2, and the first wr_clock is high in the cycle after edge t2.
  - Per word: 1 LOAD cycle minimum + 2*WORD_BYTES cycles.
  - The burst address continues across words; it is not reloaded per word.
- abort: sampled in LOAD/SETUP/STROBE.
  - Next state is FIN with aborted=1 alongside done. we and wr_clock go low in that same next cycle.
  - In STROBE, the strobe of the current cycle completes; no further strobes follow.
  - abort in IDLE/FIN is ignored. aborted=0 on normal completion.
- Simultaneous abort and word_valid in LOAD: abort wins, and the word is not consumed (word_ready is deasserted in FIN).
- Asynchronous reset mid-burst: immediate return to reset values. No done pulse; partial writes remain in RAM.
- words_left and byte_idx never underflow; FIN is entered exactly when both reach their terminal values.

Test Plan:
- Single word: addr=0x10, len=1, msb_first=0, word=0xA1B2C3D4 -> writes (0x10,D4),(0x11,C3),(0x12,B2),(0x13,A1). Exactly 4 wr_clock pulses, each preceded by a SETUP cycle with we=1. done pulses once, aborted=0. First strobe is 3 cycles after start.
- Big-endian burst: addr=0x20, len=2, msb_first=1, words 0x11223344, 0x55667788 -> addresses 0x20..0x27 receive 11,22,33,44,55,66,77,88. word_ready high exactly 2 transfer cycles.
- Address wrap: NUMBER=256, addr=0xFE, len=1, word=0x0A0B0C0D, msb_first=0 -> (0xFE,0D),(0xFF,0C),(0x00,0B),(0x01,0A).
- Stream stall plus len=0: hold word_valid low for 5 cycles between words -> we=0 throughout the stall and no strobes. Separately, len=0 -> done one cycle after start, zero strobes.
- Abort: abort asserted during the 2nd STROBE of word 1 (len=3) -> exactly 2 strobes total, done=1 with aborted=1 next cycle, ready=1 after. A start during the burst is ignored.
- Reset mid-burst: assert reset during SETUP -> all outputs at reset values immediately, no done. A new burst after reset completes normally.
